// File: rtl/mux5_arbiter.sv
// Round-robin arbiter for a shared 5:1 mux: one-hot grant, registered select,
// bounded ownership of MAX_HOLD cycles whenever another requester is waiting.
module mux5_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] req,
   output logic [4:0] gnt,
   output logic [2:0] sel,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [2:0] IDLE_SEL = 3'b101;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   state_t     fsm, fsm_n;
   logic [2:0] owner, owner_n;
   logic [2:0] ptr, ptr_n;
   logic [7:0] hold_cnt, hold_cnt_n;
   logic [4:0] gnt_n;
   logic [2:0] sel_n;
   logic       own_req, others;

   // Index arithmetic wraps at 5, never at 8.
   function automatic logic [2:0] inc5(input logic [2:0] x);
      return (x == 3'd4) ? 3'd0 : x + 3'd1;
   endfunction

   function automatic logic [2:0] pick(input logic [4:0] r, input logic [2:0] start);
      logic [2:0] idx;
      logic [2:0] res;
      logic       found;
      idx   = start;
      res   = start;
      found = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (!found && r[idx]) begin
            res   = idx;
            found = 1'b1;
         end
         idx = inc5(idx);
      end
      return res;
   endfunction

   assign own_req = |(req & (5'b00001 << owner));
   assign others  = |(req & ~(5'b00001 << owner));

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      fsm_n      = fsm;
      owner_n    = owner;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      unique case (fsm)
         IDLE: begin
            if (req != 5'b00000) begin
               owner_n    = pick(req, ptr);
               ptr_n      = inc5(owner_n);
               hold_cnt_n = 8'd1;
               fsm_n      = GRANT;
            end
         end
         GRANT: begin
            if (!own_req && others) begin
               owner_n    = pick(req, inc5(owner));
               ptr_n      = inc5(owner_n);
               hold_cnt_n = 8'd1;
            end else if (!own_req) begin
               fsm_n      = IDLE;
               hold_cnt_n = 8'd0;
            end else if (hold_cnt == HOLD_MAX && others) begin
               owner_n    = pick(req, inc5(owner));
               ptr_n      = inc5(owner_n);
               hold_cnt_n = 8'd1;
            end else if (hold_cnt == HOLD_MAX) begin
               // Sole requester: re-arm the window, grant stays continuous.
               hold_cnt_n = 8'd1;
            end else begin
               hold_cnt_n = hold_cnt + 8'd1;
            end
         end
         default: fsm_n = IDLE;
      endcase

      gnt_n = 5'b00000;
      sel_n = IDLE_SEL;
      if (fsm_n == GRANT) begin
         gnt_n = 5'b00001 << owner_n;
         sel_n = owner_n;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm      <= IDLE;
         owner    <= 3'd0;
         ptr      <= 3'd0;
         hold_cnt <= 8'd0;
         gnt      <= 5'b00000;
         sel      <= IDLE_SEL;
         busy     <= 1'b0;
      end else begin
         fsm      <= fsm_n;
         owner    <= owner_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_cnt_n;
         gnt      <= gnt_n;
         sel      <= sel_n;
         busy     <= (fsm_n == GRANT);
      end
   end

endmodule

// File: tb/tb_mux5_arbiter.sv
// Directed bench for mux5_arbiter: reset, solo hold, full contention, early
// release, modulo-5 wrap and reset in the middle of a grant.
module tb_mux5_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] req;
   logic [4:0] gnt;
   logic [2:0] sel;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   mux5_arbiter #(.MAX_HOLD(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected grant given by index 0..4, or 5 for idle.
   task automatic expect_owner(input string tag, input int idx);
      logic [4:0] g;
      g = (idx < 5) ? (5'b00001 << idx) : 5'b00000;
      check({tag, ".gnt"}, {3'b000, gnt}, {3'b000, g});
      check({tag, ".sel"}, {5'b00000, sel}, 8'(idx));
      check({tag, ".busy"}, {7'b0, busy}, {7'b0, (idx < 5)});
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 5'b11111;

      // Reset holds the grant off despite full requests.
      for (int i = 0; i < 2; i++) begin
         step();
         expect_owner("reset", 5);
      end

      // Full contention: each owner holds exactly 8 cycles, rotating 0..4.
      rst_n = 1'b1;
      for (int c = 0; c < 45; c++) begin
         step();
         expect_owner($sformatf("contend%0d", c), (c / 8) % 5);
      end

      // Solo hold across the re-arm points.
      rst_n = 1'b0;
      req   = 5'b00100;
      step();
      expect_owner("reset2", 5);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         expect_owner($sformatf("solo%0d", c), 2);
      end
      req = 5'b00000;
      step();
      expect_owner("solo_release", 5);

      // Early release hands over with no idle bubble.
      rst_n = 1'b0;
      step();
      expect_owner("reset3", 5);
      rst_n = 1'b1;
      req   = 5'b01010;
      for (int c = 0; c < 3; c++) begin
         step();
         expect_owner($sformatf("early%0d", c), 1);
      end
      req = 5'b01000;
      step();
      expect_owner("early_switch", 3);

      // Wrap: owner 4 releases, next owner is 0 (4+1 mod 5), then 1 after 8.
      req = 5'b10000;
      step();
      expect_owner("to_owner4", 4);
      req = 5'b00011;
      for (int c = 0; c < 8; c++) begin
         step();
         expect_owner($sformatf("wrap%0d", c), 0);
      end
      step();
      expect_owner("wrap_fair", 1);

      // Reset while owner 3 is at hold_cnt=5.
      req = 5'b01000;
      for (int c = 0; c < 5; c++) begin
         step();
         expect_owner($sformatf("mid%0d", c), 3);
      end
      req   = 5'b11111;
      rst_n = 1'b0;
      step();
      expect_owner("mid_reset", 5);
      rst_n = 1'b1;
      step();
      expect_owner("post_reset", 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
